// File: rtl/prism_cfg_pkg.sv
// Purpose: shared address map, state encoding and status bit layout for the PRISM config write sequencer.
// Latency: n/a (constants and helpers only).
// Backpressure: n/a.
package prism_cfg_pkg;

    // CPU-visible register map (6-bit peripheral address space)
    localparam logic [5:0] CFG_LSB_ADDR  = 6'h10;  // write starts a full latch load window
    localparam logic [5:0] CFG_MSB_ADDR  = 6'h14;  // write performs a single latch strobe
    localparam logic [5:0] CFG_CTRL_ADDR = 6'h18;  // status read / overrun clear

    // Bit positions inside the status readback word
    localparam int STAT_BUSY = 0;
    localparam int STAT_OVR  = 1;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        LOADING
    } state_t;

    // True for the two addresses that launch a sequence
    function automatic logic is_cfg_addr(input logic [5:0] addr);
        return (addr == CFG_LSB_ADDR) || (addr == CFG_MSB_ADDR);
    endfunction

endpackage

// File: rtl/prism_cfg_write_seq.sv
// Purpose: captures CPU config writes and sequences debug_wr / latch_wr toward the config latch loader.
// Latency: outputs are registered; address/data appear 1 cycle after the accepted write, strobes from 2 cycles.
// Backpressure: bus_ready is low for the whole sequence; config writes arriving then are dropped and flag overrun.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   bus_addr/wdata/wr     CPU write port (bus_wr is a one-cycle strobe)
//   bus_ready             high when a config write would be accepted
//   bus_rdata             combinational status read at CFG_CTRL_ADDR: {.., overrun, busy}
//   address, data_out     held address/data presented to the loader
//   debug_wr              one-cycle load pulse that starts the loader's shift window
//   latch_wr              latch write strobe
//   busy                  sequence in progress
//   load_done             one-cycle pulse on the last strobe of a load window
module prism_cfg_write_seq
    import prism_cfg_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  bus_addr,
    input  logic [31:0] bus_wdata,
    input  logic        bus_wr,
    output logic        bus_ready,
    output logic [31:0] bus_rdata,
    output logic [5:0]  address,
    output logic [31:0] data_out,
    output logic        debug_wr,
    output logic        latch_wr,
    output logic        busy,
    output logic        load_done
);

    // Counter must hold 0..2*DEPTH without wrapping
    localparam int                CNT_W     = $clog2(2 * DEPTH + 1);
    localparam logic [CNT_W-1:0]  CNT_END   = CNT_W'(2 * DEPTH);
    localparam logic [CNT_W-1:0]  CNT_LASTS = CNT_W'(2 * DEPTH - 1);

    // Only the low WIDTH-32 bits of an MSB word reach a latch; the rest is zeroed
    // so stale upper bits never sit on the loader's data bus.
    localparam logic [31:0] MSB_MASK = (WIDTH >= 64) ? 32'hFFFF_FFFF
                                                      : 32'((64'd1 << (WIDTH - 32)) - 64'd1);

    state_t             state_q,     state_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic [5:0]         address_q,   address_d;
    logic [31:0]        data_out_q,  data_out_d;
    logic               debug_wr_q,  debug_wr_d;
    logic               latch_wr_q,  latch_wr_d;
    logic               busy_q,      busy_d;
    logic               load_done_q, load_done_d;
    logic               overrun_q,   overrun_d;

    logic               cfg_hit;
    logic               ctrl_clr;

    assign cfg_hit  = bus_wr && is_cfg_addr(bus_addr);
    assign ctrl_clr = bus_wr && (bus_addr == CFG_CTRL_ADDR) && bus_wdata[0];

    // Next-state and next-output logic. Outputs are computed for the state being
    // entered so every output toggles on the same edge as the state it belongs to.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        address_d   = address_q;
        data_out_d  = data_out_q;
        debug_wr_d  = 1'b0;
        latch_wr_d  = 1'b0;
        busy_d      = busy_q;
        load_done_d = 1'b0;
        overrun_d   = overrun_q;

        case (state_q)
            IDLE: begin
                address_d = '0;
                busy_d    = 1'b0;
                if (cfg_hit) begin
                    state_d    = SETUP;
                    address_d  = bus_addr;
                    data_out_d = (bus_addr == CFG_MSB_ADDR) ? (bus_wdata & MSB_MASK) : bus_wdata;
                    busy_d     = 1'b1;
                end
            end

            // Address/data have had one full cycle to settle before any strobe.
            SETUP: begin
                state_d = STROBE;
                if (address_q == CFG_MSB_ADDR) begin
                    latch_wr_d = 1'b1;
                end else begin
                    debug_wr_d = 1'b1;
                end
            end

            STROBE: begin
                if (address_q == CFG_MSB_ADDR) begin
                    state_d = HOLD;
                end else begin
                    state_d = LOADING;
                    cnt_d   = '0;
                end
            end

            // Keeps data stable for one cycle after the strobe falls.
            HOLD: begin
                state_d   = IDLE;
                busy_d    = 1'b0;
                address_d = '0;
            end

            // The loader raises latch_en every second cycle after debug_wr; the
            // odd counter values line up with those cycles. The final strobe
            // doubles as load_done, and reaching 2*DEPTH retires the window.
            LOADING: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_d[0] && (cnt_d <= CNT_LASTS)) begin
                    latch_wr_d = 1'b1;
                end
                if (cnt_d == CNT_LASTS) begin
                    load_done_d = 1'b1;
                end
                if (cnt_d == CNT_END) begin
                    state_d   = IDLE;
                    busy_d    = 1'b0;
                    address_d = '0;
                end
            end

            default: begin
                state_d   = IDLE;
                busy_d    = 1'b0;
                address_d = '0;
            end
        endcase

        // Clear has priority so software can always recover the flag.
        if (ctrl_clr) begin
            overrun_d = 1'b0;
        end else if (cfg_hit && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            address_q   <= '0;
            data_out_q  <= '0;
            debug_wr_q  <= 1'b0;
            latch_wr_q  <= 1'b0;
            busy_q      <= 1'b0;
            load_done_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            address_q   <= address_d;
            data_out_q  <= data_out_d;
            debug_wr_q  <= debug_wr_d;
            latch_wr_q  <= latch_wr_d;
            busy_q      <= busy_d;
            load_done_q <= load_done_d;
            overrun_q   <= overrun_d;
        end
    end

    // Status readback is combinational on the address
    always_comb begin
        bus_rdata = '0;
        if (bus_addr == CFG_CTRL_ADDR) begin
            bus_rdata[STAT_BUSY] = busy_q;
            bus_rdata[STAT_OVR]  = overrun_q;
        end
    end

    assign bus_ready = !busy_q;
    assign address   = address_q;
    assign data_out  = data_out_q;
    assign debug_wr  = debug_wr_q;
    assign latch_wr  = latch_wr_q;
    assign busy      = busy_q;
    assign load_done = load_done_q;

endmodule

// File: tb/tb_prism_cfg_write_seq.sv
// Purpose: self-checking bench for prism_cfg_write_seq at DEPTH 4, 8 and 16 driven in parallel.
// Latency: n/a.
// Backpressure: n/a.
module tb_prism_cfg_write_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [5:0]  bus_addr  = 6'h0;
    logic [31:0] bus_wdata = 32'h0;
    logic        bus_wr    = 1'b0;

    logic [2:0]  bus_ready_v, debug_wr_v, latch_wr_v, busy_v, load_done_v;
    logic [31:0] bus_rdata_v [3];
    logic [5:0]  address_v   [3];
    logic [31:0] data_out_v  [3];

    always #5 clk = ~clk;

    // Instance g has DEPTH = 4 << g (4, 8, 16); instance 1 is the default build.
    for (genvar g = 0; g < 3; g++) begin : g_dut
        prism_cfg_write_seq #(.DEPTH(4 << g), .WIDTH(64)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .bus_addr  (bus_addr),
            .bus_wdata (bus_wdata),
            .bus_wr    (bus_wr),
            .bus_ready (bus_ready_v[g]),
            .bus_rdata (bus_rdata_v[g]),
            .address   (address_v[g]),
            .data_out  (data_out_v[g]),
            .debug_wr  (debug_wr_v[g]),
            .latch_wr  (latch_wr_v[g]),
            .busy      (busy_v[g]),
            .load_done (load_done_v[g])
        );
    end

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d: got %h, expected %h at %0t", name, inst, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Per instance: which sequence is running (0 none, 1 MSB, 2 LSB) and how many
    // cycles have elapsed since the write was accepted.
    int          m_kind [3] = '{0, 0, 0};
    int          m_age  [3] = '{0, 0, 0};
    logic [31:0] m_data [3] = '{32'h0, 32'h0, 32'h0};
    logic [5:0]  m_addr [3] = '{6'h0, 6'h0, 6'h0};
    logic        m_ovr  [3] = '{1'b0, 1'b0, 1'b0};

    function automatic int seq_len(input int kind, input int inst);
        return (kind == 1) ? 3 : 2 * (4 << inst) + 2;
    endfunction

    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                m_kind[i] <= 0;
                m_age[i]  <= 0;
                m_data[i] <= 32'h0;
                m_addr[i] <= 6'h0;
                m_ovr[i]  <= 1'b0;
            end else begin
                if (bus_wr && (bus_addr == 6'h10 || bus_addr == 6'h14) && m_kind[i] == 0) begin
                    m_kind[i] <= (bus_addr == 6'h10) ? 2 : 1;
                    m_age[i]  <= 1;
                    m_data[i] <= bus_wdata;
                    m_addr[i] <= bus_addr;
                end else if (m_kind[i] != 0) begin
                    if (m_age[i] >= seq_len(m_kind[i], i)) m_kind[i] <= 0;
                    m_age[i] <= m_age[i] + 1;
                end
                if (bus_wr && bus_addr == 6'h18 && bus_wdata[0])
                    m_ovr[i] <= 1'b0;
                else if (bus_wr && (bus_addr == 6'h10 || bus_addr == 6'h14) && m_kind[i] != 0)
                    m_ovr[i] <= 1'b1;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            for (int i = 0; i < 3; i++) begin
                automatic int   k  = m_kind[i];
                automatic int   a  = m_age[i];
                automatic int   d  = 4 << i;
                automatic logic eb = (k != 0);
                // LSB: strobes 2,4,..,2D cycles after debug_wr (which is at age 2)
                automatic logic el = ((k == 1) && (a == 2)) ||
                                     ((k == 2) && (a >= 4) && (a <= 2 * d + 2) && (a % 2 == 0));
                automatic logic ed = (k == 2) && (a == 2);
                automatic logic eo = (k == 2) && (a == 2 * d + 2);
                automatic logic [31:0] er = (bus_addr == 6'h18) ? {30'h0, m_ovr[i], eb} : 32'h0;
                chk("mon_busy",      i, 32'(busy_v[i]),      32'(eb));
                chk("mon_bus_ready", i, 32'(bus_ready_v[i]), 32'(!eb));
                chk("mon_latch_wr",  i, 32'(latch_wr_v[i]),  32'(el));
                chk("mon_debug_wr",  i, 32'(debug_wr_v[i]),  32'(ed));
                chk("mon_load_done", i, 32'(load_done_v[i]), 32'(eo));
                chk("mon_address",   i, 32'(address_v[i]),   32'(eb ? m_addr[i] : 6'h0));
                chk("mon_data_out",  i, data_out_v[i],       m_data[i]);
                chk("mon_rdata",     i, bus_rdata_v[i],      er);
            end
        end
    end

    // ---------------- directed vectors (checked on the DEPTH=8 instance) ----------------
    typedef struct {
        logic [5:0]  addr;
        logic [31:0] wdata;
        logic        wr;
        int          wait_n;   // cycles after the op to check; 0 = no check, next op follows at once
        logic        e_busy;
        logic        e_ovr;
        logic [31:0] e_data;
        logic [5:0]  e_addr;
        logic [31:0] e_rdata;  // for whatever bus_addr is present at the check cycle
    } vec_t;

    vec_t tbl [12];

    task automatic set_idle();
        bus_addr  = 6'h18;
        bus_wdata = 32'h0;
        bus_wr    = 1'b0;
    endtask

    task automatic apply(input logic [5:0] a, input logic [31:0] d, input logic w);
        @(negedge clk);
        #1;
        bus_addr  = a;
        bus_wdata = d;
        bus_wr    = w;
    endtask

    task automatic check_reset_vals(input string tag);
        for (int i = 0; i < 3; i++) begin
            chk({tag, "_busy"},      i, 32'(busy_v[i]),      32'h0);
            chk({tag, "_bus_ready"}, i, 32'(bus_ready_v[i]), 32'h1);
            chk({tag, "_latch_wr"},  i, 32'(latch_wr_v[i]),  32'h0);
            chk({tag, "_debug_wr"},  i, 32'(debug_wr_v[i]),  32'h0);
            chk({tag, "_load_done"}, i, 32'(load_done_v[i]), 32'h0);
            chk({tag, "_address"},   i, 32'(address_v[i]),   32'h0);
            chk({tag, "_data_out"},  i, data_out_v[i],       32'h0);
            chk({tag, "_rdata"},     i, bus_rdata_v[i],      32'h0);
        end
    endtask

    int lat_n [3], first_lat [3], dbg_at [3], done_at [3], idle_at [3];

    initial begin
        //          addr   wdata          wr  wait busy ovr  data           addr   rdata
        tbl[0]  = '{6'h14, 32'hA5A5_0003, 1'b1, 1, 1'b1, 1'b0, 32'hA5A5_0003, 6'h14, 32'h0};
        tbl[1]  = '{6'h18, 32'h0,         1'b0, 2, 1'b0, 1'b0, 32'hA5A5_0003, 6'h00, 32'h0};
        tbl[2]  = '{6'h10, 32'h1234_5678, 1'b1, 1, 1'b1, 1'b0, 32'h1234_5678, 6'h10, 32'h0};
        tbl[3]  = '{6'h18, 32'h0,         1'b0, 2, 1'b1, 1'b0, 32'h1234_5678, 6'h10, 32'h1};
        tbl[4]  = '{6'h14, 32'hDEAD_BEEF, 1'b1, 2, 1'b1, 1'b1, 32'h1234_5678, 6'h10, 32'h3};
        tbl[5]  = '{6'h18, 32'h1,         1'b1, 1, 1'b1, 1'b0, 32'h1234_5678, 6'h10, 32'h1};
        tbl[6]  = '{6'h14, 32'h0,         1'b1, 0, 1'b1, 1'b1, 32'h1234_5678, 6'h10, 32'h3};
        tbl[7]  = '{6'h18, 32'h1,         1'b1, 1, 1'b1, 1'b0, 32'h1234_5678, 6'h10, 32'h1};
        tbl[8]  = '{6'h18, 32'h0,         1'b0, 6, 1'b0, 1'b0, 32'h1234_5678, 6'h00, 32'h0};
        tbl[9]  = '{6'h20, 32'h55,        1'b1, 2, 1'b0, 1'b0, 32'h1234_5678, 6'h00, 32'h0};
        tbl[10] = '{6'h14, 32'h0000_0007, 1'b1, 1, 1'b1, 1'b0, 32'h0000_0007, 6'h14, 32'h0};
        tbl[11] = '{6'h18, 32'h0,         1'b0, 3, 1'b0, 1'b0, 32'h0000_0007, 6'h00, 32'h0};

        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        #1 rst = 1'b0;
        mon_en = 1'b1;
        set_idle();

        // Directed table
        for (int n = 0; n < 12; n++) begin
            apply(tbl[n].addr, tbl[n].wdata, tbl[n].wr);
            for (int j = 1; j <= tbl[n].wait_n; j++) begin
                @(negedge clk);
                if (j == tbl[n].wait_n) begin
                    chk($sformatf("vec%0d_busy", n),  1, 32'(busy_v[1]),    32'(tbl[n].e_busy));
                    chk($sformatf("vec%0d_ovr", n),   1, 32'(m_ovr[1]) | 32'(bus_rdata_v[1][1] & (bus_addr == 6'h18)), 32'(tbl[n].e_ovr));
                    chk($sformatf("vec%0d_data", n),  1, data_out_v[1],     tbl[n].e_data);
                    chk($sformatf("vec%0d_addr", n),  1, 32'(address_v[1]), 32'(tbl[n].e_addr));
                    chk($sformatf("vec%0d_rdata", n), 1, bus_rdata_v[1],    tbl[n].e_rdata);
                end
                #1 set_idle();
            end
        end

        // Load-window timing for every DEPTH
        repeat (40) @(negedge clk);
        apply(6'h10, 32'h0BAD_F00D, 1'b1);
        for (int i = 0; i < 3; i++) begin
            lat_n[i] = 0; first_lat[i] = 0; dbg_at[i] = 0; done_at[i] = 0; idle_at[i] = 0;
        end
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (latch_wr_v[i]) begin
                    lat_n[i]++;
                    if (first_lat[i] == 0) first_lat[i] = c;
                end
                if (debug_wr_v[i])  dbg_at[i]  = c;
                if (load_done_v[i]) done_at[i] = c;
                if (!busy_v[i] && idle_at[i] == 0) idle_at[i] = c;
            end
            if (c == 1) #1 set_idle();
        end
        for (int i = 0; i < 3; i++) begin
            chk("sweep_latch_count", i, 32'(lat_n[i]),     32'(4 << i));
            chk("sweep_first_latch", i, 32'(first_lat[i]), 32'd4);
            chk("sweep_debug_cycle", i, 32'(dbg_at[i]),    32'd2);
            chk("sweep_done_cycle",  i, 32'(done_at[i]),   32'(2 * (4 << i) + 2));
            chk("sweep_idle_cycle",  i, 32'(idle_at[i]),   32'(2 * (4 << i) + 3));
            chk("sweep_data_held",   i, data_out_v[i],     32'h0BAD_F00D);
        end

        // Asynchronous reset in the middle of a load
        repeat (5) @(negedge clk);
        apply(6'h10, 32'h0C0F_FEE0, 1'b1);
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            if (c == 1) #1 set_idle();
        end
        #1 rst = 1'b1;
        #1 check_reset_vals("midrst");
        @(negedge clk);
        #1 rst = 1'b0;
        apply(6'h10, 32'h1357_9BDF, 1'b1);
        @(negedge clk);
        #1 set_idle();
        @(negedge clk);
        chk("postrst_debug_wr", 1, 32'(debug_wr_v[1]), 32'h1);
        chk("postrst_address",  1, 32'(address_v[1]),  32'h10);
        chk("postrst_data",     1, data_out_v[1],      32'h1357_9BDF);
        repeat (40) @(negedge clk);

        // Randomized traffic checked by the model
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            #1;
            case ($urandom_range(0, 4))
                0:       bus_addr = 6'h10;
                1:       bus_addr = 6'h14;
                2:       bus_addr = 6'h18;
                3:       bus_addr = 6'h20;
                default: bus_addr = 6'($urandom);
            endcase
            bus_wdata = $urandom;
            bus_wr    = ($urandom_range(0, 3) == 0);
        end
        @(negedge clk);
        #1 set_idle();
        repeat (40) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
